axi4_lite_write_master_q: RTL and testbench

Queued, parametrised AXI4-Lite write master.
- Accepts write commands through a valid/ready command port into an internal FIFO.
- Issues AW and W with independent handshakes, so the slave may accept address and data in different cycles.
- Tracks up to MAX_OUTSTANDING unanswered writes.
- Reports every B response to the local side.
- Sits between a core-side store path (or DMA) and the AXI4-Lite interconnect.

---
 rtl/axi4_lite_pkg.sv | 20 ++
 rtl/axi4_lite_cmd_fifo.sv | 53 +++++
 rtl/axi4_lite_write_master_q.sv | 147 ++++++++++++++
 tb/tb_axi4_lite_write_master_q.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the queued AXI4-Lite write master: response codes and issue FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_t;

  function automatic logic is_err_resp(input logic [1:0] resp);
    return (resp == SLVERR) || (resp == DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_cmd_fifo.sv
// First-word-fall-through command FIFO; head is valid whenever empty_o is low.
module axi4_lite_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic [PTR_W:0]   count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   rd_q, rd_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (PTR_W + 1)'(1);
    if (pop_ok)  rd_d = rd_q + (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[PTR_W-1:0]] <= data_i;
  end

  assign count_o = wr_q - rd_q;
  assign full_o  = (count_o == (PTR_W + 1)'(DEPTH));
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/axi4_lite_write_master_q.sv
// Queued AXI4-Lite write master: buffers commands, issues AW/W independently,
// bounds outstanding writes and reports each B response locally.
module axi4_lite_write_master_q #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CMD_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int STRB_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  busy,
  output logic                  resp_valid,
  output logic [1:0]            resp_code,
  output logic                  err_sticky,
  input  logic                  err_clear,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);
  import axi4_lite_pkg::*;

  localparam int FIFO_W = ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;
  localparam int FCNT_W = $clog2(CMD_DEPTH) + 1;
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                  fifo_full, fifo_empty, push, pop;
  logic [FIFO_W-1:0]     head;
  logic [FCNT_W-1:0]     fifo_cnt, fifo_cnt_nxt;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [STRB_WIDTH-1:0] head_strb;

  issue_state_t     state_q, state_d;
  logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_code_q, resp_code_d;
  logic             err_q, err_d;
  logic             aw_hs, w_hs, b_hs, issue_done, can_issue;

  axi4_lite_cmd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({cmd_addr, cmd_data, cmd_strb}),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head),
    .count_o (fifo_cnt)
  );

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid & cmd_ready;
  assign {head_addr, head_data, head_strb} = head;

  assign M_AXI_AWVALID = (state_q == ST_ISSUE) & !aw_done_q;
  assign M_AXI_WVALID  = (state_q == ST_ISSUE) & !w_done_q;
  assign M_AXI_AWADDR  = M_AXI_AWVALID ? head_addr : '0;
  assign M_AXI_WDATA   = M_AXI_WVALID ? head_data : '0;
  assign M_AXI_WSTRB   = M_AXI_WVALID ? head_strb : '0;
  assign M_AXI_BREADY  = (outst_q != '0);

  assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs       = M_AXI_BVALID & M_AXI_BREADY;
  assign issue_done = (state_q == ST_ISSUE) & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign pop        = issue_done;

  always_comb begin
    outst_d = outst_q;
    if (issue_done && !b_hs)      outst_d = outst_q + CNT_W'(1);
    else if (!issue_done && b_hs) outst_d = outst_q - CNT_W'(1);
  end

  // Look at the post-cycle FIFO occupancy so a push into an idle block issues next cycle.
  assign fifo_cnt_nxt = fifo_cnt + FCNT_W'(push) - FCNT_W'(pop);
  assign can_issue    = (fifo_cnt_nxt != '0) && (outst_d < MAX_CNT);

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (state_q == ST_IDLE) begin
      if (can_issue) state_d = ST_ISSUE;
    end else if (issue_done) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      state_d   = can_issue ? ST_ISSUE : ST_IDLE;
    end else begin
      if (aw_hs) aw_done_d = 1'b1;
      if (w_hs)  w_done_d  = 1'b1;
    end
  end

  // A same-cycle error response takes priority over err_clear.
  always_comb begin
    resp_valid_d = b_hs;
    resp_code_d  = b_hs ? M_AXI_BRESP : resp_code_q;
    err_d        = err_q;
    if (b_hs && is_err_resp(M_AXI_BRESP)) err_d = 1'b1;
    else if (err_clear)                   err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      outst_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      outst_q      <= outst_d;
      resp_valid_q <= resp_valid_d;
      resp_code_q  <= resp_code_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_code  = resp_code_q;
  assign err_sticky = err_q;
  assign busy       = !fifo_empty | (state_q == ST_ISSUE) | (outst_q != '0);

endmodule

// File: tb/tb_axi4_lite_write_master_q.sv
// Bench for axi4_lite_write_master_q: scoreboarded AXI slave model, vector table and corner sequences.
module tb_axi4_lite_write_master_q;

  localparam int MAXO = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    bit          clr;
    logic [1:0]  exp_code;
    bit          exp_err;
  } vec_t;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_strb;
  logic        busy, resp_valid, err_sticky, err_clear;
  logic [1:0]  resp_code;
  logic [31:0] AWADDR, WDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [1:0]  BRESP;

  int checks, failures;
  int aw_cnt, w_cnt, b_cnt, rv_cnt, issued_prev;
  bit rv_exp, err_m;
  bit awv_prev, awhs_prev, wv_prev, whs_prev;
  logic [31:0] awaddr_prev;
  logic [35:0] wpay_prev;
  cmd_t aw_q[$], w_q[$];
  logic [1:0] resp_q[$];

  bit aw_rdy_en, w_rdy_en, b_en, spur, clr_on_b;
  logic [1:0] bresp_cur;
  vec_t vecs[5];
  int pushed, n, aw0, rv0;
  bit acc, found;

  axi4_lite_write_master_q #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .busy(busy), .resp_valid(resp_valid), .resp_code(resp_code),
    .err_sticky(err_sticky), .err_clear(err_clear),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int issued_now();
    return (aw_cnt < w_cnt) ? aw_cnt : w_cnt;
  endfunction

  // Observes the cycle at the falling edge; all handshakes seen here complete at the next rising edge.
  task automatic mon();
    int outst;
    bit bhs;
    cmd_t e;
    if (!rst_n) begin
      aw_q.delete(); w_q.delete(); resp_q.delete();
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; issued_prev = 0;
      rv_exp = 0; err_m = 0;
      awv_prev = 0; awhs_prev = 0; wv_prev = 0; whs_prev = 0;
      return;
    end
    outst = issued_now() - b_cnt;
    chk("bready", BREADY, outst != 0);
    chk("outst_max", outst <= MAXO, 1);
    chk("resp_valid", resp_valid, rv_exp);
    chk("err_sticky", err_sticky, err_m);
    if (!AWVALID) chk("awaddr_zero", AWADDR, 0);
    if (!WVALID) chk("w_zero", {WDATA, WSTRB}, 0);
    if (awv_prev && !awhs_prev) begin
      chk("aw_hold", AWVALID, 1);
      chk("aw_stable", AWADDR, awaddr_prev);
    end
    if (wv_prev && !whs_prev) begin
      chk("w_hold", WVALID, 1);
      chk("w_stable", {WDATA, WSTRB}, wpay_prev);
    end
    if (resp_valid) begin
      chk("resp_sb_nonempty", resp_q.size() != 0, 1);
      if (resp_q.size() != 0) chk("resp_code", resp_code, resp_q.pop_front());
      rv_cnt++;
    end
    if (cmd_valid && cmd_ready) begin
      e = '{addr: cmd_addr, data: cmd_data, strb: cmd_strb};
      aw_q.push_back(e);
      w_q.push_back(e);
    end
    if (AWVALID && AWREADY) begin
      chk("aw_sb_nonempty", aw_q.size() != 0, 1);
      if (aw_q.size() != 0) begin
        e = aw_q.pop_front();
        chk("aw_addr", AWADDR, e.addr);
      end
      aw_cnt++;
    end
    if (WVALID && WREADY) begin
      chk("w_sb_nonempty", w_q.size() != 0, 1);
      if (w_q.size() != 0) begin
        e = w_q.pop_front();
        chk("w_payload", {WDATA, WSTRB}, {e.data, e.strb});
      end
      w_cnt++;
    end
    bhs = BVALID && BREADY;
    if (bhs) begin
      resp_q.push_back(BRESP);
      b_cnt++;
    end
    err_m  = (bhs && BRESP[1]) ? 1'b1 : (err_clear ? 1'b0 : err_m);
    rv_exp = bhs;
    awv_prev = AWVALID; awhs_prev = AWVALID && AWREADY; awaddr_prev = AWADDR;
    wv_prev = WVALID; whs_prev = WVALID && WREADY; wpay_prev = {WDATA, WSTRB};
  endtask

  // Slave model: B for a write appears one cycle after it becomes visible as issued.
  task automatic drive();
    bit breal;
    AWREADY = aw_rdy_en;
    WREADY  = w_rdy_en;
    breal   = b_en && (issued_prev > b_cnt);
    BVALID  = breal || spur;
    BRESP   = bresp_cur;
    err_clear = clr_on_b && breal;
    issued_prev = issued_now();
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_addr = a; cmd_data = d; cmd_strb = s; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy || BVALID) && k < 100) begin
      cyc();
      k++;
    end
    chk(name, busy, 0);
    cyc();
    cyc();
  endtask

  initial begin
    checks = 0; failures = 0; rv_cnt = 0;
    cmd_valid = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0; err_clear = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    aw_rdy_en = 1; w_rdy_en = 1; b_en = 1; spur = 0; clr_on_b = 0; bresp_cur = 2'b00;
    vecs[0] = '{32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 2'b00, 0};
    vecs[1] = '{32'h2000_0004, 32'h1234_5678, 4'h3, 2'b01, 0, 2'b01, 0};
    vecs[2] = '{32'h3000_0008, 32'hA5A5_5A5A, 4'hC, 2'b10, 0, 2'b10, 1};
    vecs[3] = '{32'h4000_000C, 32'h0000_0000, 4'h1, 2'b00, 0, 2'b00, 1};
    vecs[4] = '{32'h5000_0000, 32'hFFFF_FFFF, 4'hF, 2'b11, 1, 2'b11, 1};

    rst_n = 0;
    repeat (3) cyc();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err", err_sticky, 0);
    rst_n = 1;
    cyc();

    // Single write: valids at N+1, response at N+4.
    send(32'h1000_0010, 32'hDEAD_BEEF, 4'hF);
    chk("t1_awvalid_n1", AWVALID, 1);
    chk("t1_wvalid_n1", WVALID, 1);
    chk("t1_awaddr_n1", AWADDR, 32'h1000_0010);
    cyc();
    chk("t1_awvalid_n2", AWVALID, 0);
    chk("t1_wvalid_n2", WVALID, 0);
    cyc();
    chk("t1_resp_n3", resp_valid, 0);
    cyc();
    chk("t1_resp_n4", resp_valid, 1);
    chk("t1_code_n4", resp_code, 2'b00);
    chk("t1_busy_n4", busy, 0);
    wait_idle("t1_idle");

    // Split handshake: AW accepted at once, W three cycles later.
    w_rdy_en = 0;
    send(32'h0000_0ABC, 32'hCAFE_F00D, 4'h5);
    chk("t2_awvalid_n1", AWVALID, 1);
    chk("t2_wvalid_n1", WVALID, 1);
    cyc();
    chk("t2_awvalid_drop", AWVALID, 0);
    chk("t2_wvalid_hold", WVALID, 1);
    chk("t2_wdata", WDATA, 32'hCAFE_F00D);
    cyc();
    cyc();
    chk("t2_wvalid_n4", WVALID, 1);
    w_rdy_en = 1; WREADY = 1;
    cyc();
    chk("t2_wvalid_done", WVALID, 0);
    chk("t2_awvalid_done", AWVALID, 0);
    chk("t2_bready_outst1", BREADY, 1);
    chk("t2_busy", busy, 1);
    wait_idle("t2_idle");

    // Response/error vectors.
    for (int i = 0; i < 5; i++) begin
      chk("vec_cmd_ready", cmd_ready, 1);
      bresp_cur = vecs[i].bresp;
      clr_on_b  = vecs[i].clr;
      send(vecs[i].addr, vecs[i].data, vecs[i].strb);
      found = 0;
      for (int k = 0; k < 20; k++) begin
        if (resp_valid) begin
          found = 1;
          break;
        end
        cyc();
      end
      chk("vec_resp_seen", found, 1);
      chk("vec_resp_code", resp_code, vecs[i].exp_code);
      chk("vec_err_sticky", err_sticky, vecs[i].exp_err);
      clr_on_b = 0;
      bresp_cur = 2'b00;
      cyc();
      cyc();
    end
    err_clear = 1;
    cyc();
    chk("err_clear_alone", err_sticky, 0);
    wait_idle("t4_idle");

    // Spurious BVALID with nothing outstanding.
    spur = 1; BVALID = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_bready", BREADY, 0);
      chk("t5_resp_valid", resp_valid, 0);
      chk("t5_busy", busy, 0);
    end
    spur = 0; BVALID = 0;
    cyc();

    // Saturation: B held off, six commands pushed.
    b_en = 0;
    aw0 = aw_cnt;
    pushed = 0; n = 0;
    while (pushed < 6 && n < 40) begin
      cmd_addr = 32'h8000_0000 + 32'(pushed * 4);
      cmd_data = 32'h0BAD_0000 + 32'(pushed);
      cmd_strb = 4'hF;
      cmd_valid = 1;
      acc = cmd_ready;
      cyc();
      if (acc) pushed++;
      n++;
    end
    cmd_valid = 0;
    chk("t3_pushed", pushed, 6);
    repeat (4) cyc();
    chk("t3_issued", aw_cnt - aw0, MAXO);
    chk("t3_cmd_ready_full", cmd_ready, 0);
    chk("t3_busy", busy, 1);
    b_en = 1;
    rv0 = rv_cnt;
    n = 0;
    while ((rv_cnt - rv0) < 6 && n < 80) begin
      cyc();
      n++;
    end
    chk("t3_resp_count", rv_cnt - rv0, 6);
    chk("t3_all_issued", aw_cnt - aw0, 6);
    wait_idle("t3_idle");

    // Reset mid-issue with two entries queued behind the head.
    aw_rdy_en = 0; w_rdy_en = 0;
    send(32'h9000_0000, 32'h1111_1111, 4'hF);
    send(32'h9000_0004, 32'h2222_2222, 4'hF);
    send(32'h9000_0008, 32'h3333_3333, 4'hF);
    chk("t6_pre_awvalid", AWVALID, 1);
    chk("t6_pre_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("t6_awvalid", AWVALID, 0);
    chk("t6_wvalid", WVALID, 0);
    chk("t6_busy", busy, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_awaddr", AWADDR, 0);
    cyc();
    rst_n = 1;
    aw_rdy_en = 1; w_rdy_en = 1; AWREADY = 1; WREADY = 1;
    cyc();
    chk("t6_post_busy", busy, 0);
    send(32'hA000_0040, 32'h5555_AAAA, 4'h6);
    chk("t6_post_awvalid", AWVALID, 1);
    chk("t6_post_awaddr", AWADDR, 32'hA000_0040);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("t6_post_resp", found, 1);
    chk("t6_post_code", resp_code, 2'b00);
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
